mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
Memory-stage access controller, the successor to the MEM-stage size decoder. It decodes the load/store opcode and generates byte enables and aligned write data. It runs a req/ack handshake to a variable-latency data bus, stalling the pipeline until the access completes. It also extends load data and flags address/bus exceptions.

Parameters:
ADDR_W, 32, width of bus_addr and addr
TIMEOUT, 15, max cycles bus_req may wait for bus_ack (used only with MEM_TIMEOUT_EN); counter width $clog2(TIMEOUT+1)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
valid_in  in  1  MEM-stage instruction valid; inputs held stable while stall_out=1
inst  in  32  MEM-stage instruction
addr  in  ADDR_W  effective address
wdata  in  32  store data (rt)
stall_out  out  1  freeze pipeline at and before MEM
done  out  1  one-cycle pulse: access finished, rdata_out/exc valid
rdata_out  out  32  extended load result
exc  out  2  0 none, 1 AdEL, 2 AdES, 3 BUSERR
bus_req  out  1  access request
bus_we  out  1  1 = store
bus_addr  out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00})
bus_be  out  4  byte enables
bus_wdata  out  32  lane-replicated store data
bus_ack  in  1  access complete; bus_rdata valid in same cycle
bus_rdata  in  32  read word

Behaviour:
- Memory ops (opcode = inst[31:26]): lb 100000, lbu 100100, lh 100001, lhu 100101, lw 100011, sb 101000, sh 101001, sw 101011. Size from inst[27:26]: 00 byte, 01 half, 11 word. inst[29]=store. inst[28]=zero-extend (loads).
- Any other opcode, or valid_in=0: no stall, no done, no bus activity.
- Misalignment: half with addr[0]=1, or word with addr[1:0]!=0. Result: no bus request, no stall. done=1 combinationally in the same cycle, exc=1 for loads, 2 for stores, rdata_out=0.
- FSM states IDLE, REQ, DONE:
  - IDLE -> REQ on valid_in & aligned memop. Latch we/addr/be/wdata/size/ext into registers.
  - REQ: bus_req=1, bus signals held constant from registers. On bus_ack=1, capture bus_rdata and go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE. No new request is accepted in DONE.
- stall_out = (IDLE & valid_in & aligned memop) | REQ. It is low in DONE, so the pipeline advances in the done cycle.
- Minimum latency (ack in first REQ cycle): 2 stall cycles, done in cycle 3.
- Byte enables:
  - byte: 4'b0001 << addr[1:0]
  - half: 4'b0011 << {addr[1],1'b0}
  - word: 4'b1111
  - Loads drive the same be.
- bus_wdata: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word wdata.
- Load extension: select the lane by the latched addr[1:0]. Sign-extend when inst[28]=0, zero-extend when inst[28]=1. Stores give rdata_out=0.
- Register reset values: state=IDLE, bus_req=0, bus_we=0, bus_addr=0, bus_be=0, bus_wdata=0, done=0, rdata_out=0, exc=0.
- Reset in REQ or DONE: immediate return to IDLE, bus_req drops asynchronously, and the access is abandoned.
- bus_ack while not in REQ is ignored.

Optional Feature:
MEM_TIMEOUT_EN:
- Defined: a counter clears on entry to REQ and increments each REQ cycle without ack. When it reaches TIMEOUT, bus_req drops and the FSM goes to DONE with exc=3, rdata_out=0. An ack in the same cycle as the timeout wins (normal completion).
- Undefined: REQ waits indefinitely, exc never equals 3, no counter logic exists.

Decomposition:
- Shared header/package mem_defs: opcode constants, size codes, exc codes (EXC_NONE, EXC_ADEL, EXC_ADES, EXC_BUSERR), FSM state encodings.
- One combinational sub-module, mem_lane_align, produces be, replicated wdata, the misalign flag and the extended load data. The top level holds the FSM, registers and the timeout counter.

Test Plan:
1. sw addr=0x1004 wdata=0xDEADBEEF, ack on first REQ cycle -> bus_be=1111, bus_we=1, bus_addr=0x1004. stall for 2 cycles, done in cycle 3, exc=0.
2. lb addr=0x2003, bus_rdata=0x80FF0011, ack after 3 wait cycles -> bus_be=1000, rdata_out=0xFFFFFF80. lbu on the same data -> 0x00000080.
3. sh addr=0x3002 wdata=0x0000ABCD -> bus_be=1100, bus_wdata=0xABCDABCD. lh addr=0x3001 -> no bus_req, done same cycle, exc=1.
4. sw addr=0x4002 -> exc=2, no stall, no bus_req. Non-memory opcode (addu) with valid_in=1 -> stall_out=0, done=0.
5. Assert reset during REQ -> bus_req=0 immediately, all outputs 0. Next valid lw restarts cleanly.
6. With MEM_TIMEOUT_EN, TIMEOUT=4, lw with ack never asserted -> bus_req high for 4 cycles, then done with exc=3, rdata_out=0. Without the macro, stall persists.

Source files
------------

// File: rtl/mem_access_ctrl_pkg.sv
// ============================================================================
// Module   : mem_access_ctrl_pkg
// Brief    : Shared memory-stage definitions: load/store opcodes, access size
//            codes, exception codes, controller FSM states and a memop helper.
// Options  : none (MEM_TIMEOUT_EN is consumed by mem_access_ctrl)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_access_ctrl_pkg;

  // Load/store opcodes, inst[31:26]
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;

  // Access size, inst[27:26]
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b11;

  // Exception codes reported on exc
  localparam logic [1:0] EXC_NONE   = 2'd0;
  localparam logic [1:0] EXC_ADEL   = 2'd1;
  localparam logic [1:0] EXC_ADES   = 2'd2;
  localparam logic [1:0] EXC_BUSERR = 2'd3;

  // Bus access FSM
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // True for the eight supported load/store opcodes only
  function automatic logic is_memop(input logic [5:0] op);
    logic r;
    case (op)
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW: r = 1'b1;
      default:                                                 r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_access_ctrl_if.sv
// ============================================================================
// Module   : mem_access_ctrl_if
// Brief    : req/ack data-bus bundle between the memory-stage controller
//            (master) and a variable-latency memory (slave).
// Options  : none
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_access_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [3:0]        bus_be;
  logic [31:0]       bus_wdata;
  logic              bus_ack;
  logic [31:0]       bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface

`default_nettype wire

// File: rtl/mem_access_ctrl_lane_align.sv
// ============================================================================
// Module   : mem_lane_align
// Brief    : Combinational lane logic. Store side: byte enables, replicated
//            write data and misalignment flag from the live request. Load
//            side: lane select and sign/zero extension of the returned word
//            using the latched size/offset.
// Options  : none
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_lane_align
  import mem_access_ctrl_pkg::*;
(
  input  logic [1:0]  req_size,
  input  logic [1:0]  req_addr_lo,
  input  logic [31:0] req_wdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic        misalign,
  input  logic [1:0]  ld_size,
  input  logic [1:0]  ld_addr_lo,
  input  logic        ld_zext,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_ext
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Request-side enables, lane replication and alignment check
  always_comb begin
    be        = 4'b1111;
    wdata_rep = req_wdata;
    misalign  = 1'b0;
    case (req_size)
      SZ_BYTE: begin
        be        = 4'b0001 << req_addr_lo;
        wdata_rep = {4{req_wdata[7:0]}};
      end
      SZ_HALF: begin
        be        = 4'b0011 << {req_addr_lo[1], 1'b0};
        wdata_rep = {2{req_wdata[15:0]}};
        misalign  = req_addr_lo[0];
      end
      default: begin
        misalign  = (req_addr_lo != 2'b00);
      end
    endcase
  end

  // Load-side lane pick and extension
  always_comb begin
    w_half = ld_addr_lo[1] ? ld_word[31:16] : ld_word[15:0];
    case (ld_addr_lo)
      2'd0:    w_byte = ld_word[7:0];
      2'd1:    w_byte = ld_word[15:8];
      2'd2:    w_byte = ld_word[23:16];
      default: w_byte = ld_word[31:24];
    endcase
    case (ld_size)
      SZ_BYTE: ld_ext = {{24{~ld_zext & w_byte[7]}}, w_byte};
      SZ_HALF: ld_ext = {{16{~ld_zext & w_half[15]}}, w_half};
      default: ld_ext = ld_word;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_access_ctrl.sv
// ============================================================================
// Module   : mem_access_ctrl
// Brief    : Memory-stage access controller. Decodes load/store opcodes,
//            runs a req/ack handshake to a variable-latency bus while
//            stalling the pipeline, extends load data and reports address
//            and bus exceptions.
// Options  : `define MEM_TIMEOUT_EN adds a bus timeout (TIMEOUT cycles,
//            reported as BUSERR). Without it REQ waits indefinitely.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 32
`ifdef MEM_TIMEOUT_EN
  , parameter int TIMEOUT = 15
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_in,
  input  logic [31:0]       inst,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              stall_out,
  output logic              done,
  output logic [31:0]       rdata_out,
  output logic [1:0]        exc,
  mem_access_ctrl_if.master bus
);

  state_t      r_state;
  logic        r_done;
  logic [1:0]  r_exc;
  logic [31:0] r_rdata;
  logic [1:0]  r_size;
  logic [1:0]  r_addr_lo;
  logic        r_zext;

  logic        w_memop;
  logic        w_store;
  logic        w_misalign;
  logic        w_mis_hit;
  logic        w_start;
  logic        w_timeout;
  logic [3:0]  w_be;
  logic [31:0] w_wdata_rep;
  logic [31:0] w_ld_ext;
  logic        w_unused_inst;

  // Only the opcode field matters here
  assign w_unused_inst = ^inst[25:0];

  assign w_memop = valid_in & is_memop(inst[31:26]);
  assign w_store = inst[29];

  mem_lane_align u_lane (
    .req_size    (inst[27:26]),
    .req_addr_lo (addr[1:0]),
    .req_wdata   (wdata),
    .be          (w_be),
    .wdata_rep   (w_wdata_rep),
    .misalign    (w_misalign),
    .ld_size     (r_size),
    .ld_addr_lo  (r_addr_lo),
    .ld_zext     (r_zext),
    .ld_word     (bus.bus_rdata),
    .ld_ext      (w_ld_ext)
  );

  // A misaligned access never reaches the bus; it completes in its own cycle
  assign w_mis_hit = (r_state == ST_IDLE) & w_memop & w_misalign;
  assign w_start   = (r_state == ST_IDLE) & w_memop & ~w_misalign;

  assign stall_out = w_start | (r_state == ST_REQ);
  assign done      = r_done | w_mis_hit;
  assign exc       = w_mis_hit ? (w_store ? EXC_ADES : EXC_ADEL) : r_exc;
  assign rdata_out = w_mis_hit ? 32'd0 : r_rdata;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] r_cnt;

  // The cycle whose increment would make the count reach TIMEOUT ends REQ
  assign w_timeout = (r_cnt == CNT_W'(TIMEOUT - 1));

  // Counts REQ cycles that passed without an ack
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_start) begin
      r_cnt <= '0;
    end else if ((r_state == ST_REQ) && !bus.bus_ack) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  // Access FSM with registered bus outputs and completion results
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      bus.bus_req   <= 1'b0;
      bus.bus_we    <= 1'b0;
      bus.bus_addr  <= '0;
      bus.bus_be    <= 4'b0000;
      bus.bus_wdata <= 32'd0;
      r_done        <= 1'b0;
      r_exc         <= EXC_NONE;
      r_rdata       <= 32'd0;
      r_size        <= SZ_BYTE;
      r_addr_lo     <= 2'b00;
      r_zext        <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_state       <= ST_REQ;
            bus.bus_req   <= 1'b1;
            bus.bus_we    <= w_store;
            bus.bus_addr  <= {addr[ADDR_W-1:2], 2'b00};
            bus.bus_be    <= w_be;
            bus.bus_wdata <= w_wdata_rep;
            r_size        <= inst[27:26];
            r_addr_lo     <= addr[1:0];
            r_zext        <= inst[28];
          end
        end
        ST_REQ: begin
          // ack takes priority over a timeout in the same cycle
          if (bus.bus_ack) begin
            r_state     <= ST_DONE;
            bus.bus_req <= 1'b0;
            r_done      <= 1'b1;
            r_exc       <= EXC_NONE;
            r_rdata     <= bus.bus_we ? 32'd0 : w_ld_ext;
          end else if (w_timeout) begin
            r_state     <= ST_DONE;
            bus.bus_req <= 1'b0;
            r_done      <= 1'b1;
            r_exc       <= EXC_BUSERR;
            r_rdata     <= 32'd0;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
          r_exc   <= EXC_NONE;
          r_rdata <= 32'd0;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
// ============================================================================
// Module   : tb_mem_access_ctrl
// Brief    : Self-checking bench for mem_access_ctrl: directed cases plus
//            randomized loads/stores against a behavioural model.
// Options  : `define MEM_TIMEOUT_EN builds the DUT with TIMEOUT=4
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mem_access_ctrl;

  localparam int ADDR_W = 32;
`ifdef MEM_TIMEOUT_EN
  localparam int  TMO    = 4;
  localparam bit  TMO_ON = 1'b1;
`else
  localparam int  TMO    = 1000000;
  localparam bit  TMO_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in;
  logic [31:0] inst;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall_out;
  logic        done;
  logic [31:0] rdata_out;
  logic [1:0]  exc;

  int n_vec = 0;
  int n_err = 0;

  mem_access_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  mem_access_ctrl #(
    .ADDR_W (ADDR_W)
`ifdef MEM_TIMEOUT_EN
    , .TIMEOUT (TMO)
`endif
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (valid_in),
    .inst      (inst),
    .addr      (addr),
    .wdata     (wdata),
    .stall_out (stall_out),
    .done      (done),
    .rdata_out (rdata_out),
    .exc       (exc),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, expv, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic bit is_mem(input logic [5:0] op);
    logic [5:0] ops [8] = '{6'b100000, 6'b100100, 6'b100001, 6'b100101,
                            6'b100011, 6'b101000, 6'b101001, 6'b101011};
    foreach (ops[i]) if (ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int nbytes(input logic [5:0] op);
    case (op[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  // Byte i enabled when it lies inside the naturally-aligned group
  function automatic logic [3:0] be_model(input int nb, input logic [31:0] a);
    logic [3:0] r;
    int base;
    r = 4'b0000;
    base = (int'(a[1:0]) / nb) * nb;
    for (int i = 0; i < 4; i++) r[i] = (i >= base) && (i < base + nb);
    return r;
  endfunction

  function automatic logic [31:0] wd_model(input int nb, input logic [31:0] wd);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % nb) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ld_model(input logic [5:0] op, input logic [31:0] a,
                                           input logic [31:0] word);
    int nb;
    logic [31:0] v, mask;
    nb = nbytes(op);
    if (nb == 4) return word;
    v    = word >> (8 * int'(a[1:0]));
    mask = (32'h1 << (8 * nb)) - 32'h1;
    v    = v & mask;
    if (!op[2] && v[8*nb-1]) v = v | ~mask;
    return v;
  endfunction

  // ---------------- one pipeline instruction ----------------
  // wait_n = REQ cycles without ack before the acking cycle
  task automatic do_op(input bit v, input logic [5:0] op, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] rword, input int wait_n);
    bit mem, st, mis, tmo;
    int nb, nreq;
    logic [1:0]  e_exc;
    logic [31:0] e_rd;
    @(negedge clk);
    valid_in      = v;
    inst          = {op, 26'($urandom)};
    addr          = a;
    wdata         = wd;
    bus.bus_ack   = 1'b0;
    bus.bus_rdata = $urandom;
    #1;
    mem = v && is_mem(op);
    st  = op[3];
    nb  = nbytes(op);
    mis = (nb == 2 && a[0]) || (nb == 4 && a[1:0] != 2'b00);
    if (!mem) begin
      chk("idle_stall", 32'(stall_out), 32'd0);
      chk("idle_done", 32'(done), 32'd0);
      chk("idle_req", 32'(bus.bus_req), 32'd0);
    end else if (mis) begin
      chk("mis_stall", 32'(stall_out), 32'd0);
      chk("mis_done", 32'(done), 32'd1);
      chk("mis_exc", 32'(exc), st ? 32'd2 : 32'd1);
      chk("mis_rdata", rdata_out, 32'd0);
      chk("mis_req", 32'(bus.bus_req), 32'd0);
    end else begin
      chk("acc_stall", 32'(stall_out), 32'd1);
      chk("acc_done", 32'(done), 32'd0);
      chk("acc_req", 32'(bus.bus_req), 32'd0);
      tmo  = TMO_ON && (wait_n >= TMO);
      nreq = tmo ? TMO : wait_n + 1;
      for (int k = 0; k < nreq; k++) begin
        @(negedge clk);
        bus.bus_ack   = (k == wait_n);
        bus.bus_rdata = (k == wait_n) ? rword : $urandom;
        #1;
        chk("req_req", 32'(bus.bus_req), 32'd1);
        chk("req_stall", 32'(stall_out), 32'd1);
        chk("req_done", 32'(done), 32'd0);
        chk("req_we", 32'(bus.bus_we), 32'(st));
        chk("req_addr", bus.bus_addr, {a[31:2], 2'b00});
        chk("req_be", 32'(bus.bus_be), 32'(be_model(nb, a)));
        if (st) chk("req_wdata", bus.bus_wdata, wd_model(nb, wd));
      end
      // DONE cycle; a stray ack here must be ignored
      @(negedge clk);
      bus.bus_ack   = 1'($urandom);
      bus.bus_rdata = $urandom;
      #1;
      e_exc = tmo ? 2'd3 : 2'd0;
      e_rd  = (tmo || st) ? 32'd0 : ld_model(op, a, rword);
      chk("done_done", 32'(done), 32'd1);
      chk("done_stall", 32'(stall_out), 32'd0);
      chk("done_req", 32'(bus.bus_req), 32'd0);
      chk("done_exc", 32'(exc), 32'(e_exc));
      chk("done_rdata", rdata_out, e_rd);
    end
  endtask

  // Quiet cycle with a stray ack, nothing may happen
  task automatic idle_cycle();
    @(negedge clk);
    valid_in      = 1'b0;
    bus.bus_ack   = 1'($urandom);
    bus.bus_rdata = $urandom;
    #1;
    chk("gap_done", 32'(done), 32'd0);
    chk("gap_req", 32'(bus.bus_req), 32'd0);
    chk("gap_stall", 32'(stall_out), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [5:0] op_tab [12] = '{6'b100000, 6'b100100, 6'b100001, 6'b100101,
                                6'b100011, 6'b101000, 6'b101001, 6'b101011,
                                6'b000000, 6'b100010, 6'b101010, 6'b001001};
    logic [5:0]  op;
    logic [31:0] a;
    reset         = 1'b1;
    valid_in      = 1'b0;
    inst          = '0;
    addr          = '0;
    wdata         = '0;
    bus.bus_ack   = 1'b0;
    bus.bus_rdata = '0;
    #1;
    chk("rst_req", 32'(bus.bus_req), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_exc", 32'(exc), 32'd0);
    chk("rst_rdata", rdata_out, 32'd0);
    chk("rst_be", 32'(bus.bus_be), 32'd0);
    chk("rst_addr", bus.bus_addr, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Directed cases
    do_op(1, 6'b101011, 32'h0000_1004, 32'hDEAD_BEEF, 32'h0, 0);   // sw
    chk("sw_be_lit", 32'(bus.bus_be), 32'hF);
    do_op(1, 6'b100000, 32'h0000_2003, 32'h0, 32'h80FF_0011, 3);   // lb
    chk("lb_lit", rdata_out, 32'hFFFF_FF80);
    do_op(1, 6'b100100, 32'h0000_2003, 32'h0, 32'h80FF_0011, 1);   // lbu
    chk("lbu_lit", rdata_out, 32'h0000_0080);
    do_op(1, 6'b101001, 32'h0000_3002, 32'h0000_ABCD, 32'h0, 0);   // sh
    chk("sh_wdata_lit", bus.bus_wdata, 32'hABCD_ABCD);
    do_op(1, 6'b100001, 32'h0000_3001, 32'h0, 32'h0, 0);           // lh misaligned
    do_op(1, 6'b101011, 32'h0000_4002, 32'h1234_5678, 32'h0, 0);   // sw misaligned
    do_op(1, 6'b000000, 32'h0000_0000, 32'h0, 32'h0, 0);           // addu
    idle_cycle();

    // Reset in the middle of REQ
    do_op(0, 6'b000000, 32'h0, 32'h0, 32'h0, 0);
    @(negedge clk);
    valid_in = 1'b1;
    inst     = {6'b100011, 26'h0};
    addr     = 32'h0000_5000;
    @(negedge clk);
    #1;
    chk("pre_rst_req", 32'(bus.bus_req), 32'd1);
    #2;
    reset    = 1'b1;
    valid_in = 1'b0;
    #1;
    chk("arst_req", 32'(bus.bus_req), 32'd0);
    chk("arst_stall", 32'(stall_out), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_exc", 32'(exc), 32'd0);
    chk("arst_rdata", rdata_out, 32'd0);
    chk("arst_addr", bus.bus_addr, 32'd0);
    chk("arst_be", 32'(bus.bus_be), 32'd0);
    chk("arst_we", 32'(bus.bus_we), 32'd0);
    chk("arst_wdata", bus.bus_wdata, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    do_op(1, 6'b100011, 32'h0000_5004, 32'h0, 32'hCAFE_F00D, 2);   // lw restart

    // No ack for a long time: timeout fires, or the stall just persists
    do_op(1, 6'b100011, 32'h0000_6000, 32'h0, 32'h1357_9BDF, 20);
    idle_cycle();

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      op = op_tab[$urandom_range(0, 11)];
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      if ($urandom_range(0, 3) == 0) a[1:0] = (nbytes(op) == 2) ? 2'b10 : a[1:0];
      do_op($urandom_range(0, 9) != 0, op, a, $urandom, $urandom,
            TMO_ON ? $urandom_range(0, 6) : $urandom_range(0, 5));
      if ($urandom_range(0, 4) == 0) idle_cycle();
    end
    idle_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
